data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Y86-64 data memory behind memory_access; serves its read_en/write_en/addr/write_data requests.
//  Byte-addressed, little-endian, 8-byte (quad) accesses with a fixed multi-cycle latency.
//  The request/done handshake lets the pipeline controller stall the M stage until the access completes.
//  Reports out-of-range or conflicting requests on dmem_error_o, which feeds the stat/exception logic.
// PARAMETERS
//  MEM_BYTES  1024  storage size in bytes; legal addresses are 0..MEM_BYTES-8
//  LATENCY    2     cycles from request accept to done_o; legal range 1..15
// PORTS
//  clk_i          in   1   single clock; all state updates on rising edge
//  rst_i          in   1   asynchronous, active-high reset
//  read_en_i      in   1   read request (mrmovq/ret/popq)
//  write_en_i     in   1   write request (rmmovq/call/pushq)
//  addr_i         in   64  byte address of the quad
//  write_data_i   in   64  store data, little-endian into addr..addr+7
//  read_data_o    out  64  load result (valM); valid when done_o=1, held until next accept
//  busy_o         out  1   access in flight; upstream holds its request while 1
//  done_o         out  1   one-cycle pulse: access complete
//  dmem_error_o   out  1   error for completed access; valid with done_o, held until next accept
// BEHAVIOUR
//  Reset: state=IDLE, count=0, busy_o=0, done_o=0, read_data_o=0, dmem_error_o=0.
//   Array contents are not cleared by reset.
//  FSM states:
//   IDLE: if read_en_i|write_en_i, capture addr/data/op, count=LATENCY-1, go BUSY, busy_o=1 next cycle.
//   BUSY: count decrements each cycle; at count==0 go DONE.
//   DONE: done_o=1, busy_o=0 for exactly one cycle, then IDLE.
//  Latency: request sampled in cycle N -> done_o high in cycle N+LATENCY+1.
//  Request inputs are ignored outside IDLE; no queueing.
//  Error condition: (read_en_i & write_en_i) or captured addr > MEM_BYTES-8.
//   Address compare is full 64-bit unsigned; addr near 2^64 must not wrap into range.
//   On error: no array write, read_data_o=0, dmem_error_o=1 in DONE.
//  Write: bytes addr..addr+7 = write_data_i[7:0]..[63:56], committed in the DONE cycle only.
//  Read: read_data_o loaded in DONE from bytes addr..addr+7, little-endian; dmem_error_o=0.
//  Back-to-back: a request present in the cycle after DONE (state IDLE) is accepted normally.
//  Read after write to the same address returns the new data.
//  Reset mid-operation (BUSY or DONE): abort; no write is committed, outputs return to reset values.
//  Unaligned addresses are legal; there is no alignment error.
// STRUCTURE
//  define.v (shared): add `DMEM_IDLE/`DMEM_BUSY/`DMEM_DONE 2-bit state codes next to the icode defines.
//  Sub-module dmem_array: MEM_BYTES x 8 storage.
//   8-byte combinational read port at base address.
//   8-byte synchronous write with write enable; no reset.
//  data_memory holds the FSM, latency counter, capture registers and error logic.
// TESTING
//  1 Reset: assert rst_i mid-cycle -> all outputs 0 immediately (async); busy_o=0.
//  2 Write/read: write addr=0x10, data=0x1122334455667788, then read 0x10.
//     Read -> read_data_o=0x1122334455667788, done_o at N+3 (LATENCY=2), dmem_error_o=0.
//     Byte-level: a read at 0x11 returns 0x0011223344556677 (upper byte = prior byte at 0x18, zeroed).
//  3 Range: read at MEM_BYTES-8 -> ok; read at MEM_BYTES-7 -> dmem_error_o=1, read_data_o=0.
//     Write at 0xFFFFFFFFFFFFFFF8 -> error; a later read of 0x0 is unchanged.
//  4 Conflict: read_en_i=write_en_i=1 at 0x20 -> dmem_error_o=1; memory at 0x20 unchanged.
//  5 Handshake: toggle addr_i/read_en_i while busy_o=1 -> ignored; a back-to-back request
//     the cycle after done_o is accepted; done_o is exactly one cycle wide.
//  6 Reset in BUSY during a write to 0x40 -> a read of 0x40 after reset returns the old value.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types for the Y86-64 data memory: FSM state encoding and sizing constants.
package data_memory_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  localparam int unsigned DMEM_QUAD_BYTES = 8;
  localparam int unsigned DMEM_CNT_W      = 4;

endpackage

// File: rtl/data_memory_dmem_array.sv
// Byte storage for the data memory: 8-byte little-endian combinational read, synchronous 8-byte write.
module dmem_array
  import data_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];

  always_comb begin
    rdata_o = '0;
    for (int unsigned k = 0; k < DMEM_QUAD_BYTES; k++) begin
      rdata_o[8*k +: 8] = mem_q[addr_i + AW'(k)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < DMEM_QUAD_BYTES; k++) begin
        mem_q[addr_i + AW'(k)] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Y86-64 data memory: request/done handshake with fixed latency, range and conflict error reporting.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        read_en_i,
  input  logic        write_en_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] write_data_i,
  output logic [63:0] read_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        dmem_error_o
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  is_write_q, is_write_d;
  logic                  err_q, err_d;
  logic                  derr_q, derr_d;
  logic                  accept, finish, array_we;
  logic [63:0]           array_rdata;

  dmem_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (array_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (array_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= DMEM_IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      derr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      derr_q     <= derr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMEM_IDLE: if (read_en_i | write_en_i) state_d = DMEM_BUSY;
      DMEM_BUSY: if (count_q == '0) state_d = DMEM_DONE;
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // Result and error are registered on entry to DONE so they are valid alongside done_o;
  // the error decision (full 64-bit range compare) is taken at accept time.
  always_comb begin
    accept     = (state_q == DMEM_IDLE) & (read_en_i | write_en_i);
    finish     = (state_q == DMEM_BUSY) & (count_q == '0);
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    err_d      = err_q;
    derr_d     = derr_q;
    if (accept) begin
      count_d    = DMEM_CNT_W'(LATENCY - 1);
      addr_d     = addr_i[AW-1:0];
      wdata_d    = write_data_i;
      is_write_d = write_en_i;
      err_d      = (read_en_i & write_en_i) | (addr_i > 64'(MEM_BYTES - DMEM_QUAD_BYTES));
      rdata_d    = '0;
      derr_d     = 1'b0;
    end else if (finish) begin
      rdata_d = (err_q || is_write_q) ? '0 : array_rdata;
      derr_d  = err_q;
    end else if (state_q == DMEM_BUSY) begin
      count_d = count_q - DMEM_CNT_W'(1);
    end
  end

  always_comb begin
    busy_o       = (state_q == DMEM_BUSY);
    done_o       = (state_q == DMEM_DONE);
    array_we     = (state_q == DMEM_DONE) & is_write_q & ~err_q;
    read_data_o  = rdata_q;
    dmem_error_o = derr_q;
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (MEM_BYTES=1024, LATENCY=2).
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [63:0] read_data;
  logic        busy, done, derr;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [63:0] r_data;
  logic        r_err;
  int unsigned r_cyc;

  data_memory #(
    .MEM_BYTES (1024),
    .LATENCY   (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .read_en_i    (read_en),
    .write_en_i   (write_en),
    .addr_i       (addr),
    .write_data_i (wdata),
    .read_data_o  (read_data),
    .busy_o       (busy),
    .done_o       (done),
    .dmem_error_o (derr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, wait (bounded) for done_o, return to IDLE.
  task automatic access(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] data, output logic err, output int unsigned cyc);
    @(negedge clk);
    read_en = rd; write_en = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    read_en = 1'b0; write_en = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    data = read_data;
    err  = derr;
    check("latency", 64'(cyc), 64'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    // 1: reset values
    #7;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", read_data, 64'd0);
    check("rst_err", 64'(derr), 64'd0);
    @(negedge clk); rst = 1'b0;

    // preload known contents
    access(1'b0, 1'b1, 64'h18, 64'h0, r_data, r_err, r_cyc);
    check("wr18_err", 64'(r_err), 64'd0);
    access(1'b0, 1'b1, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, r_data, r_err, r_cyc);
    access(1'b0, 1'b1, 64'h20, 64'hCAFE_F00D_DEAD_BEEF, r_data, r_err, r_cyc);
    access(1'b0, 1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, r_data, r_err, r_cyc);
    access(1'b0, 1'b1, 64'd1016, 64'h8877_6655_4433_2211, r_data, r_err, r_cyc);

    // 2: write/read, byte-level little-endian
    access(1'b0, 1'b1, 64'h10, 64'h1122_3344_5566_7788, r_data, r_err, r_cyc);
    check("wr10_err", 64'(r_err), 64'd0);
    check("wr10_rdata", r_data, 64'd0);
    access(1'b1, 1'b0, 64'h10, 64'h0, r_data, r_err, r_cyc);
    check("rd10_data", r_data, 64'h1122_3344_5566_7788);
    check("rd10_err", 64'(r_err), 64'd0);
    access(1'b1, 1'b0, 64'h11, 64'h0, r_data, r_err, r_cyc);
    check("rd11_data", r_data, 64'h0011_2233_4455_6677);
    access(1'b1, 1'b0, 64'h14, 64'h0, r_data, r_err, r_cyc);
    check("rd14_data", r_data, 64'h0000_0000_1122_3344);

    // 3: range
    access(1'b1, 1'b0, 64'd1016, 64'h0, r_data, r_err, r_cyc);
    check("rd_top_data", r_data, 64'h8877_6655_4433_2211);
    check("rd_top_err", 64'(r_err), 64'd0);
    access(1'b1, 1'b0, 64'd1017, 64'h0, r_data, r_err, r_cyc);
    check("rd_oor_err", 64'(r_err), 64'd1);
    check("rd_oor_data", r_data, 64'd0);
    access(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_DEAD_DEAD_DEAD, r_data, r_err, r_cyc);
    check("wr_wrap_err", 64'(r_err), 64'd1);
    access(1'b1, 1'b0, 64'h0, 64'h0, r_data, r_err, r_cyc);
    check("rd0_after_wrap", r_data, 64'hA5A5_5A5A_0F0F_F0F0);
    access(1'b1, 1'b0, 64'd1016, 64'h0, r_data, r_err, r_cyc);
    check("rd_top_after_wrap", r_data, 64'h8877_6655_4433_2211);

    // 4: conflicting request
    access(1'b1, 1'b1, 64'h20, 64'h0, r_data, r_err, r_cyc);
    check("conf_err", 64'(r_err), 64'd1);
    check("conf_data", r_data, 64'd0);
    access(1'b1, 1'b0, 64'h20, 64'h0, r_data, r_err, r_cyc);
    check("conf_mem", r_data, 64'hCAFE_F00D_DEAD_BEEF);
    check("conf_clr_err", 64'(r_err), 64'd0);

    // 5: handshake -- requests ignored while busy, back-to-back after done
    @(negedge clk);
    read_en = 1'b1; addr = 64'h10;
    @(posedge clk); #1;
    check("hs_busy0", 64'(busy), 64'd1);
    read_en = 1'b0; write_en = 1'b1; addr = 64'h20; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    addr = 64'h28; read_en = 1'b1;
    @(posedge clk); #1;
    check("hs_busy1", 64'(busy), 64'd1);
    check("hs_nodone", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("hs_done", 64'(done), 64'd1);
    check("hs_done_busy", 64'(busy), 64'd0);
    check("hs_data", read_data, 64'h1122_3344_5566_7788);
    read_en = 1'b1; write_en = 1'b0; addr = 64'h0;
    @(posedge clk); #1;
    check("hs_pulse_w", 64'(done), 64'd0);
    check("hs_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("hs_b2b_acc", 64'(busy), 64'd1);
    read_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hs_b2b_done", 64'(done), 64'd1);
    check("hs_b2b_data", read_data, 64'hA5A5_5A5A_0F0F_F0F0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 64'h20, 64'h0, r_data, r_err, r_cyc);
    check("hs_ignored_wr", r_data, 64'hCAFE_F00D_DEAD_BEEF);

    // 6: reset while BUSY aborts the write
    @(negedge clk);
    write_en = 1'b1; addr = 64'h40; wdata = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    write_en = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_rdata", read_data, 64'd0);
    check("mid_rst_err", 64'(derr), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 64'h40, 64'h0, r_data, r_err, r_cyc);
    check("rst_abort_mem", r_data, 64'h0123_4567_89AB_CDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
